// File: rtl/mconverter_fp2int_pkg.sv
// Shared FP16 definitions and per-lane decode record for the FP16 to block fixed-point converter.
package mconverter_fp2int_pkg;

    localparam int MPE_COL    = 16;
    localparam int FP16_EXP_W = 5;
    localparam int FP16_SIG_W = 10;
    localparam int FP16_BIAS  = 15;

    // All-ones exponent marks Inf/NaN.
    localparam logic [FP16_EXP_W-1:0] FP16_EXP_MAX = FP16_EXP_W'(2 * FP16_BIAS + 1);

    typedef struct packed {
        logic                  sign;
        logic [FP16_EXP_W-1:0] exp;
        logic [FP16_SIG_W-1:0] mant;
    } fp16_t;

    typedef struct packed {
        logic                  sign;
        logic [FP16_EXP_W-1:0] e;
        logic [FP16_SIG_W:0]   m;
        logic                  special;
        logic                  nan;
    } lane_t;

    function automatic logic [FP16_EXP_W-1:0] maxExp(input logic [FP16_EXP_W-1:0] a,
                                                     input logic [FP16_EXP_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mconverter_fp2int_fp16_unpack.sv
// Combinational decode of one FP16 lane into exponent, significand with hidden bit, and special flags.
module fp16_unpack
    import mconverter_fp2int_pkg::*;
(
    input  fp16_t fp_i,
    output lane_t lane_o
);

    // Subnormals and zero share exponent 1 with a cleared hidden bit so they align like normals.
    always_comb begin
        lane_o      = '0;
        lane_o.sign = fp_i.sign;
        if (fp_i.exp == FP16_EXP_MAX) begin
            lane_o.special = 1'b1;
            lane_o.nan     = |fp_i.mant;
        end else if (fp_i.exp == '0) begin
            lane_o.e = FP16_EXP_W'(1);
            lane_o.m = {1'b0, fp_i.mant};
        end else begin
            lane_o.e = fp_i.exp;
            lane_o.m = {1'b1, fp_i.mant};
        end
    end

endmodule

// File: rtl/mconverter_fp2int.sv
// Three-stage valid/ready pipeline turning a row of FP16 operands into signed block fixed-point
// mantissas with one shared biased exponent per row.
module mconverter_fp2int
    import mconverter_fp2int_pkg::*;
#(
    parameter int MPECol = MPE_COL,
    parameter int OUT_W  = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MPECol-1:0][15:0]       fpIn,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MPECol-1:0][OUT_W-1:0]  intOut,
    output logic [4:0]                    sharedExp,
    output logic [MPECol-1:0]             special
);

    localparam int LEVELS = (MPECol > 1) ? $clog2(MPECol) : 0;
    localparam int P      = 1 << LEVELS;
    localparam logic [OUT_W-1:0] INF_MAG = {1'b0, {(OUT_W-1){1'b1}}};

    logic                         en;
    logic                         s1Valid_q;
    fp16_t [MPECol-1:0]           s1Row_q;
    lane_t                        lane_d [MPECol];
    logic [4:0]                   maxE_d;
    logic                         s2Valid_q;
    lane_t                        s2Lane_q [MPECol];
    logic [4:0]                   s2MaxE_q;
    logic [MPECol-1:0][OUT_W-1:0] intOut_d;
    logic [MPECol-1:0]            special_d;
    logic                         outValid_q;
    logic [MPECol-1:0][OUT_W-1:0] intOut_q;
    logic [4:0]                   sharedExp_q;
    logic [MPECol-1:0]            special_q;

    // Single global stall: every stage, bubbles included, moves only when the output can drain.
    assign en       = !outValid_q | out_ready;
    assign in_ready = en;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            s1Row_q   <= '0;
        end else if (en) begin
            s1Valid_q <= in_valid;
            s1Row_q   <= fpIn;
        end
    end

    for (genvar i = 0; i < MPECol; i++) begin : g_unpack
        fp16_unpack u_unpack (
            .fp_i   (s1Row_q[i]),
            .lane_o (lane_d[i])
        );
    end

    // Max-exponent tree; specials and padding leaves contribute 0 so an all-special row yields 0.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        logic [4:0] node [P >> l];
        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < P; i++) begin : g_n
                if (i < MPECol) begin : g_real
                    assign node[i] = lane_d[i].special ? 5'd0 : lane_d[i].e;
                end else begin : g_pad
                    assign node[i] = 5'd0;
                end
            end
        end else begin : g_red
            for (genvar i = 0; i < (P >> l); i++) begin : g_n
                assign node[i] = maxExp(g_lvl[l-1].node[2*i], g_lvl[l-1].node[2*i+1]);
            end
        end
    end
    assign maxE_d = g_lvl[LEVELS].node[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            s2Valid_q <= 1'b0;
            s2Lane_q  <= '{default: '0};
            s2MaxE_q  <= '0;
        end else if (en) begin
            s2Valid_q <= s1Valid_q;
            s2Lane_q  <= lane_d;
            s2MaxE_q  <= maxE_d;
        end
    end

    // Alignment: shifts of OUT_W-1 or more flush the lane to zero; truncation is toward zero.
    always_comb begin
        logic [4:0]       sh;
        logic [OUT_W-2:0] ext;
        logic [OUT_W-2:0] mag;
        sh        = '0;
        ext       = '0;
        mag       = '0;
        intOut_d  = '0;
        special_d = '0;
        for (int i = 0; i < MPECol; i++) begin
            sh  = s2MaxE_q - s2Lane_q[i].e;
            ext = (OUT_W-1)'(s2Lane_q[i].m) << (OUT_W - 12);
            mag = (32'(sh) >= 32'(OUT_W - 1)) ? '0 : (ext >> sh);
            special_d[i] = s2Lane_q[i].special;
            if (s2Lane_q[i].special) begin
                if (s2Lane_q[i].nan) begin
                    intOut_d[i] = '0;
                end else begin
                    intOut_d[i] = s2Lane_q[i].sign ? -INF_MAG : INF_MAG;
                end
            end else begin
                intOut_d[i] = s2Lane_q[i].sign ? -{1'b0, mag} : {1'b0, mag};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_q  <= 1'b0;
            intOut_q    <= '0;
            sharedExp_q <= '0;
            special_q   <= '0;
        end else if (en) begin
            outValid_q  <= s2Valid_q;
            intOut_q    <= s2Valid_q ? intOut_d : '0;
            sharedExp_q <= s2Valid_q ? s2MaxE_q : 5'd0;
            special_q   <= s2Valid_q ? special_d : '0;
        end
    end

    assign out_valid = outValid_q;
    assign intOut    = intOut_q;
    assign sharedExp = sharedExp_q;
    assign special   = special_q;

endmodule

// File: tb/tb_mconverter_fp2int.sv
// Scoreboard bench for mconverter_fp2int: directed FP16 rows with hand-computed fixed-point results.
module tb_mconverter_fp2int;

    localparam int N = 16;
    localparam int W = 12;

    typedef logic [N-1:0][15:0]  row_t;
    typedef logic [N-1:0][W-1:0] ivec_t;

    typedef struct {
        ivec_t        iv;
        logic [4:0]   se;
        logic [N-1:0] sp;
        string        name;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    row_t         fpIn;
    logic         out_valid;
    logic         out_ready;
    ivec_t        intOut;
    logic [4:0]   sharedExp;
    logic [N-1:0] special;

    exp_t         sb[$];
    int           nChecks = 0;
    int           nPass   = 0;
    bit           heldValid = 1'b0;
    ivec_t        heldIv;
    logic [4:0]   heldSe;
    logic [N-1:0] heldSp;

    always #5 clk = ~clk;

    mconverter_fp2int #(.MPECol(N), .OUT_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fpIn      (fpIn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .intOut    (intOut),
        .sharedExp (sharedExp),
        .special   (special)
    );

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
        nChecks++;
        if (act === req) nPass++;
        else $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    endtask

    // Monitor: pops the scoreboard on every output transfer and watches stalled data for changes.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            heldValid = 1'b0;
        end else begin
            if (out_valid && !out_ready) begin
                if (heldValid) begin
                    checkOutput("hold_intOut", 256'(intOut), 256'(heldIv));
                    checkOutput("hold_sharedExp", 256'(sharedExp), 256'(heldSe));
                    checkOutput("hold_special", 256'(special), 256'(heldSp));
                end
                heldValid = 1'b1;
                heldIv    = intOut;
                heldSe    = sharedExp;
                heldSp    = special;
            end else begin
                heldValid = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_row", 256'(out_valid), 256'(0));
                end else begin
                    e = sb.pop_front();
                    checkOutput({e.name, "_intOut"}, 256'(intOut), 256'(e.iv));
                    checkOutput({e.name, "_sharedExp"}, 256'(sharedExp), 256'(e.se));
                    checkOutput({e.name, "_special"}, 256'(special), 256'(e.sp));
                end
            end
        end
    end

    task automatic applyStimulus(input row_t row, input ivec_t iv, input logic [4:0] se,
                                 input logic [N-1:0] sp, input string name);
        bit   acc;
        exp_t e;
        acc      = 1'b0;
        in_valid = 1'b1;
        fpIn     = row;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready && !rst;
            @(posedge clk);
            if (acc) begin
                e.iv = iv; e.se = se; e.sp = sp; e.name = name;
                sb.push_back(e);
            end
            #1;
        end
        in_valid = 1'b0;
        if (!acc) checkOutput({name, "_accept"}, 256'(in_ready), 256'(1));
    endtask

    task automatic waitValid(input string name);
        bit found;
        int lat;
        found = 1'b0;
        lat   = 0;
        for (int k = 1; k <= 20 && !found; k++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1'b1;
                lat   = k;
            end
        end
        checkOutput({name, "_latency"}, 256'(lat), 256'(3));
    endtask

    task automatic waitDrain(input string name);
        for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
        checkOutput({name, "_drain"}, 256'(sb.size()), 256'(0));
        @(posedge clk);
        #1;
    endtask

    function automatic row_t bpRow(input int k);
        row_t r;
        r    = '0;
        r[0] = 16'h3C00 + 16'(k);
        r[1] = 16'hBC00;
        return r;
    endfunction

    function automatic ivec_t bpIv(input int k);
        ivec_t v;
        v    = '0;
        v[0] = 12'(1024 + k);
        v[1] = 12'hC00;
        return v;
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        row_t row;
        ivec_t iv;
        int    rowIdx;
        bit    acc;
        exp_t  e;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        fpIn      = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset_out_valid", 256'(out_valid), 256'(0));
        checkOutput("reset_intOut", 256'(intOut), 256'(0));
        checkOutput("reset_sharedExp", 256'(sharedExp), 256'(0));
        checkOutput("reset_special", 256'(special), 256'(0));
        checkOutput("reset_in_ready", 256'(in_ready), 256'(1));

        row = '0; row[0] = 16'h3C00; row[1] = 16'h4000; row[2] = 16'hB800;
        iv  = '0; iv[0] = 12'd512; iv[1] = 12'd1024; iv[2] = 12'hF00;
        applyStimulus(row, iv, 5'd16, '0, "basic");
        waitValid("basic");
        waitDrain("basic");

        row = '0; row[0] = 16'h4000; row[1] = 16'h3C01; row[2] = 16'hBC01;
        iv  = '0; iv[0] = 12'd1024; iv[1] = 12'd512; iv[2] = 12'hE00;
        applyStimulus(row, iv, 5'd16, '0, "trunc");
        row = '0; row[0] = 16'h7800; row[1] = 16'h3C00;
        iv  = '0; iv[0] = 12'd1024;
        applyStimulus(row, iv, 5'd30, '0, "underflow");
        applyStimulus('0, '0, 5'd1, '0, "allzero");
        row = '0; row[0] = 16'h7C00; row[1] = 16'hFC00; row[2] = 16'h7E00; row[3] = 16'h3C00;
        iv  = '0; iv[0] = 12'h7FF; iv[1] = 12'h801; iv[3] = 12'h400;
        applyStimulus(row, iv, 5'd15, 16'h0007, "specials");
        waitDrain("directed");

        rowIdx = 0;
        for (int c = 1; c <= 40 && (rowIdx < 6 || sb.size() != 0); c++) begin
            out_ready = !(c >= 3 && c <= 8);
            in_valid  = (rowIdx < 6);
            fpIn      = bpRow(rowIdx);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (!out_ready && sb.size() == 3)
                checkOutput("bp_in_ready_drop", 256'(in_ready), 256'(0));
            @(posedge clk);
            if (acc) begin
                e.iv = bpIv(rowIdx); e.se = 5'd15; e.sp = '0;
                e.name = $sformatf("bp_row%0d", rowIdx);
                sb.push_back(e);
                rowIdx++;
            end
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("bp_rows_accepted", 256'(rowIdx), 256'(6));
        waitDrain("bp");

        for (int k = 0; k < 3; k++) applyStimulus(bpRow(10 + k), bpIv(10 + k), 5'd15, '0, "flushed");
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        checkOutput("midreset_out_valid", 256'(out_valid), 256'(0));
        checkOutput("midreset_intOut", 256'(intOut), 256'(0));
        checkOutput("midreset_sharedExp", 256'(sharedExp), 256'(0));
        checkOutput("midreset_special", 256'(special), 256'(0));
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        row = '0; row[5] = 16'h4000; row[6] = 16'hC000;
        iv  = '0; iv[5] = 12'd1024; iv[6] = 12'hC00;
        applyStimulus(row, iv, 5'd16, '0, "post_reset");
        waitValid("post_reset");
        waitDrain("post_reset");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
